// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Purpose  : Fetch-to-decode, decode-to-execute and writeback signal bundle
//            for the decode stage of the pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_rs_val;
    logic [DATA_W-1:0] out_rt_val;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [5:0]        out_funct;
    logic              out_illegal;

    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, out_pc, out_rs_val, out_rt_val, out_rd,
               out_shamt, out_funct, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, out_pc, out_rs_val, out_rt_val, out_rd,
               out_shamt, out_funct, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : R-type decode with 32-entry register file, writeback bypass and
//            a per-register busy scoreboard that stalls on RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int          DATA_W    = 32,
    parameter int          REG_INIT  = 1,
    parameter logic [5:0]  ADD_FUNCT = 6'h20
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    decode_stage_if.slave  bus
);

    localparam int c_NUM_REGS = 32;

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic              w_illegal;

    logic [31:0]       r_busy;
    logic [31:0]       w_wb_clr;
    logic [31:0]       w_busy_eff;
    logic [31:0]       w_busy_set;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;

    logic [DATA_W-1:0] w_rf [c_NUM_REGS];
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    logic              r_out_valid;
    logic [31:0]       r_out_pc;
    logic [DATA_W-1:0] r_out_rs_val;
    logic [DATA_W-1:0] r_out_rt_val;
    logic [4:0]        r_out_rd;
    logic [4:0]        r_out_shamt;
    logic [5:0]        r_out_funct;
    logic              r_out_illegal;

    assign {w_op, w_rs, w_rt, w_rd, w_shamt, w_funct} = bus.in_instr;
    assign w_illegal = (w_op != 6'd0) || (w_funct != ADD_FUNCT);

    // A writeback landing this cycle already releases its register.
    assign w_wb_clr   = bus.wb_en ? (32'd1 << bus.wb_addr) : 32'd0;
    assign w_busy_eff = r_busy & ~w_wb_clr;

    assign w_hazard   = bus.in_valid &
                        (w_busy_eff[w_rs] | w_busy_eff[w_rt] |
                         (!w_illegal & w_busy_eff[w_rd]));
    assign w_in_ready = rst_n & !w_hazard & (!r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_busy_set = (w_accept && !w_illegal && (w_rd != 5'd0)) ?
                        (32'd1 << w_rd) : 32'd0;

    // Register 0 has no storage and is hard-wired to zero.
    generate
        for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_rf
            if (i == 0) begin : g_zero
                assign w_rf[i] = '0;
            end else begin : g_reg
                localparam logic [DATA_W-1:0] c_RST_VAL =
                    (REG_INIT != 0) ? DATA_W'(i) : '0;
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_q <= c_RST_VAL;
                    end else if (bus.wb_en && (bus.wb_addr == 5'(i))) begin
                        r_q <= bus.wb_data;
                    end
                end
                assign w_rf[i] = r_q;
            end
        end
    endgenerate

    assign w_rs_val = (bus.wb_en && (bus.wb_addr == w_rs) && (w_rs != 5'd0)) ?
                      bus.wb_data : w_rf[w_rs];
    assign w_rt_val = (bus.wb_en && (bus.wb_addr == w_rt) && (w_rt != 5'd0)) ?
                      bus.wb_data : w_rf[w_rt];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy        <= 32'd0;
            r_out_valid   <= 1'b0;
            r_out_pc      <= 32'd0;
            r_out_rs_val  <= '0;
            r_out_rt_val  <= '0;
            r_out_rd      <= 5'd0;
            r_out_shamt   <= 5'd0;
            r_out_funct   <= 6'd0;
            r_out_illegal <= 1'b0;
        end else begin
            // Set has priority over a same-cycle writeback clear.
            r_busy <= (r_busy & ~w_wb_clr) | w_busy_set;
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_pc      <= bus.in_pc;
                r_out_rs_val  <= w_rs_val;
                r_out_rt_val  <= w_rt_val;
                r_out_rd      <= w_illegal ? 5'd0 : w_rd;
                r_out_shamt   <= w_shamt;
                r_out_funct   <= w_funct;
                r_out_illegal <= w_illegal;
            end else if (bus.out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_rs_val  = r_out_rs_val;
    assign bus.out_rt_val  = r_out_rt_val;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_shamt   = r_out_shamt;
    assign bus.out_funct   = r_out_funct;
    assign bus.out_illegal = r_out_illegal;

endmodule
`default_nettype wire
